// File: rtl/mu0_mem_arbiter_pkg.sv
// Shared types and constants for the MU0 memory arbiter: FSM states, port ids
// and the default bus widths of the 4096x16 MU0 memory.
package mu0_mem_pkg;

    localparam int MU0_ADDR_W      = 12;
    localparam int MU0_DATA_W      = 16;
    localparam int MU0_CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_H = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_C) ? PORT_H : PORT_C;
    endfunction

endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// Bus bundle around the arbiter: CPU (c_) and host (h_) Avalon-style requester
// ports plus the single-ported memory side (mem_).
interface mu0_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] c_address;
    logic              c_read;
    logic              c_write;
    logic [DATA_W-1:0] c_writedata;
    logic [DATA_W-1:0] c_readdata;
    logic              c_waitrequest;

    logic [ADDR_W-1:0] h_address;
    logic              h_read;
    logic              h_write;
    logic [DATA_W-1:0] h_writedata;
    logic [DATA_W-1:0] h_readdata;
    logic              h_waitrequest;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter view.
    modport slave (
        input  c_address, c_read, c_write, c_writedata,
        output c_readdata, c_waitrequest,
        input  h_address, h_read, h_write, h_writedata,
        output h_readdata, h_waitrequest,
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata
    );

    // System view: requesters and the memory model.
    modport master (
        output c_address, c_read, c_write, c_writedata,
        input  c_readdata, c_waitrequest,
        output h_address, h_read, h_write, h_writedata,
        input  h_readdata, h_waitrequest,
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata
    );

endinterface

// File: rtl/mu0_rr_pick2.sv
// Combinational two-way pick between CPU and host requests.
// MU0_ARB_HOST_PRIORITY_EN selects fixed host priority instead of round-robin.
module mu0_rr_pick2
    import mu0_mem_pkg::*;
(
    input  logic     req_c,
    input  logic     req_h,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant_id
);

    always_comb begin
        grant_valid = req_c | req_h;
        grant_id    = PORT_C;
        if (req_c && req_h) begin
`ifdef MU0_ARB_HOST_PRIORITY_EN
            grant_id = PORT_H;
`else
            grant_id = other_port(last_grant);
`endif
        end else if (req_h) begin
            grant_id = PORT_H;
        end
    end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Two-requester arbiter for the single-ported MU0 memory: IDLE/ISSUE/WAIT FSM
// with fixed read latency. MU0_ARB_HOST_PRIORITY_EN makes the host win ties.
module mu0_mem_arbiter
    import mu0_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = MU0_ADDR_W,
    parameter int DATA_W       = MU0_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    mu0_mem_arbiter_if.slave    bus,
    output logic                err
);

    localparam logic [MU0_CNT_W-1:0] CNT_INIT = MU0_CNT_W'(READ_LATENCY - 1);

    arb_state_t           state_reg;
    port_id_t             last_grant_reg;
    port_id_t             grant_reg;
    logic                 op_write_reg;
    logic [MU0_CNT_W-1:0] cnt_reg;
    logic [ADDR_W-1:0]    mem_address_reg;
    logic [DATA_W-1:0]    mem_writedata_reg;
    logic                 mem_read_reg;
    logic                 mem_write_reg;
    logic                 err_reg;

    logic [1:0]        rd_vec;
    logic [1:0]        wr_vec;
    logic [1:0]        req_vec;
    logic [1:0]        ack_vec;
    logic [1:0]        wait_vec;
    logic [ADDR_W-1:0] addr_arr     [2];
    logic [DATA_W-1:0] wdata_arr    [2];
    logic [DATA_W-1:0] readdata_arr [2];

    logic     grant_valid;
    port_id_t grant_id;
    logic     xfer_done;

    assign rd_vec       = {bus.h_read,  bus.c_read};
    assign wr_vec       = {bus.h_write, bus.c_write};
    assign req_vec      = rd_vec | wr_vec;
    assign addr_arr[0]  = bus.c_address;
    assign addr_arr[1]  = bus.h_address;
    assign wdata_arr[0] = bus.c_writedata;
    assign wdata_arr[1] = bus.h_writedata;

    mu0_rr_pick2 u_pick (
        .req_c       (req_vec[0]),
        .req_h       (req_vec[1]),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            last_grant_reg    <= PORT_H;
            grant_reg         <= PORT_C;
            op_write_reg      <= 1'b0;
            cnt_reg           <= '0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            err_reg <= err_reg | (|(rd_vec & wr_vec));
            case (state_reg)
                IDLE: begin
                    // Address, data and op are captured here; later changes are ignored.
                    if (grant_valid) begin
                        grant_reg         <= grant_id;
                        last_grant_reg    <= grant_id;
                        op_write_reg      <= wr_vec[grant_id];
                        mem_address_reg   <= addr_arr[grant_id];
                        mem_writedata_reg <= wdata_arr[grant_id];
                        mem_write_reg     <= wr_vec[grant_id];
                        mem_read_reg      <= ~wr_vec[grant_id];
                        state_reg         <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    if (op_write_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= CNT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign xfer_done = ((state_reg == ISSUE) && op_write_reg) ||
                       ((state_reg == WAIT) && (cnt_reg == '0));

    // A port that dropped its request mid-transaction sees neither ack nor data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ack_vec[gi]      = xfer_done && (int'(grant_reg) == gi);
            assign wait_vec[gi]     = rst | (req_vec[gi] & ~ack_vec[gi]);
            assign readdata_arr[gi] = (!rst && ack_vec[gi] && req_vec[gi] && !op_write_reg)
                                      ? bus.mem_readdata : '0;
        end
    endgenerate

    assign bus.c_waitrequest = wait_vec[0];
    assign bus.h_waitrequest = wait_vec[1];
    assign bus.c_readdata    = readdata_arr[0];
    assign bus.h_readdata    = readdata_arr[1];
    assign bus.mem_address   = mem_address_reg;
    assign bus.mem_writedata = mem_writedata_reg;
    assign bus.mem_read      = mem_read_reg;
    assign bus.mem_write     = mem_write_reg;
    assign err               = err_reg;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Directed self-checking bench for mu0_mem_arbiter with a 3-cycle memory model.
// Expectations follow MU0_ARB_HOST_PRIORITY_EN when it is defined.
module tb_mu0_mem_arbiter;

    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mu0_mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    mu0_mem_arbiter #(
        .READ_LATENCY (RL),
        .ADDR_W       (12),
        .DATA_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    // Memory model: read data appears RL cycles after the read strobe.
    logic [15:0] tb_mem  [0:4095];
    logic [15:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        if (bus.mem_write) tb_mem[bus.mem_address] <= bus.mem_writedata;
        rd_pipe[0] <= bus.mem_read ? tb_mem[bus.mem_address] : 16'hDEAD;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_readdata = rd_pipe[RL-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic wait_of(input bit h);
        return h ? bus.h_waitrequest : bus.c_waitrequest;
    endfunction

    function automatic logic [15:0] rdata_of(input bit h);
        return h ? bus.h_readdata : bus.c_readdata;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.c_read = 1'b0; bus.c_write = 1'b0;
        bus.h_read = 1'b0; bus.h_write = 1'b0;
    endtask

    task automatic reset_pulse;
        clear_reqs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single-port transaction; cycle 1 is the cycle in which the request is first driven.
    task automatic xfer(input bit h, input bit rd, input bit wr, input logic [11:0] a,
                        input logic [15:0] d, input int exp_cyc, input logic [15:0] exp_rd,
                        input string tag);
        int          cyc  = 0;
        int          nrd  = 0;
        bit          done = 0;
        logic [15:0] rdv  = '0;
        logic [15:0] mdv  = '0;
        if (h) begin
            bus.h_address = a; bus.h_writedata = d; bus.h_read = rd; bus.h_write = wr;
        end else begin
            bus.c_address = a; bus.c_writedata = d; bus.c_read = rd; bus.c_write = wr;
        end
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_read) nrd++;
            if (!wait_of(h)) begin
                done = 1;
                rdv  = rdata_of(h);
                mdv  = bus.mem_readdata;
            end
            tick();
        end
        if (h) begin bus.h_read = 1'b0; bus.h_write = 1'b0; end
        else   begin bus.c_read = 1'b0; bus.c_write = 1'b0; end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_cycles"}, cyc, exp_cyc);
        if (wr) begin
            check_eq({tag, "_memval"}, tb_mem[a], d);
            check_eq({tag, "_nrd"}, nrd, 0);
        end else begin
            check_eq({tag, "_rdata"}, rdv, exp_rd);
            check_eq({tag, "_passthru"}, rdv, mdv);
            check_eq({tag, "_nrd"}, nrd, 1);
        end
        $display("[%0t] %s port=%s rd=%0b wr=%0b addr=%03h wdata=%04h rdata=%04h cycles=%0d",
                 $time, tag, h ? "H" : "C", rd, wr, a, d, rdv, cyc);
    endtask

    // CPU reads 010, host reads 020 in the same cycle.
    task automatic tie(input int exp_c_at, input int exp_h_at, input string tag);
        int          cyc  = 0;
        int          c_at = 0;
        int          h_at = 0;
        logic [15:0] c_d  = '0;
        logic [15:0] h_d  = '0;
        bus.c_address = 12'h010; bus.c_read = 1'b1;
        bus.h_address = 12'h020; bus.h_read = 1'b1;
        while ((c_at == 0 || h_at == 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (c_at == 0 && !bus.c_waitrequest) begin c_at = cyc; c_d = bus.c_readdata; end
            if (h_at == 0 && !bus.h_waitrequest) begin h_at = cyc; h_d = bus.h_readdata; end
            tick();
            if (c_at != 0) bus.c_read = 1'b0;
            if (h_at != 0) bus.h_read = 1'b0;
        end
        check_eq({tag, "_c_at"}, c_at, exp_c_at);
        check_eq({tag, "_h_at"}, h_at, exp_h_at);
        check_eq({tag, "_c_data"}, c_d, 16'hBEEF);
        check_eq({tag, "_h_data"}, h_d, 16'h5A5A);
        $display("[%0t] %s C ack cycle=%0d data=%04h, H ack cycle=%0d data=%04h",
                 $time, tag, c_at, c_d, h_at, h_d);
    endtask

    initial begin
        int          order [8];
        int          n, c_n, h_n, cyc;
        bit          c_ack, h_ack;
        logic [11:0] c_next_addr;
        int          exp_port;

        bus.c_address = '0; bus.c_writedata = '0;
        bus.h_address = '0; bus.h_writedata = '0;
        bus.c_read = 1'b1; bus.c_write = 1'b0;
        bus.h_read = 1'b0; bus.h_write = 1'b1;

        // Reset state, with requests asserted during reset.
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_c_wait", bus.c_waitrequest, 1);
        check_eq("rst_h_wait", bus.h_waitrequest, 1);
        check_eq("rst_c_rdata", bus.c_readdata, 0);
        check_eq("rst_h_rdata", bus.h_readdata, 0);
        check_eq("rst_mem_read", bus.mem_read, 0);
        check_eq("rst_mem_write", bus.mem_write, 0);
        check_eq("rst_mem_addr", bus.mem_address, 0);
        check_eq("rst_err", err, 0);
        clear_reqs();
        tick();
        rst = 1'b0;

        // CPU write BEEF to 010: strobe and ack in cycle 2.
        bus.c_address = 12'h010; bus.c_writedata = 16'hBEEF; bus.c_write = 1'b1;
        @(negedge clk);
        check_eq("wr_c1_wait", bus.c_waitrequest, 1);
        check_eq("wr_c1_mem_write", bus.mem_write, 0);
        tick();
        @(negedge clk);
        check_eq("wr_c2_mem_write", bus.mem_write, 1);
        check_eq("wr_c2_mem_read", bus.mem_read, 0);
        check_eq("wr_c2_mem_addr", bus.mem_address, 12'h010);
        check_eq("wr_c2_mem_wdata", bus.mem_writedata, 16'hBEEF);
        check_eq("wr_c2_wait", bus.c_waitrequest, 0);
        tick();
        bus.c_write = 1'b0;
        @(negedge clk);
        check_eq("wr_c3_mem_write", bus.mem_write, 0);
        check_eq("wr_memval", tb_mem[12'h010], 16'hBEEF);
        $display("[%0t] wr_c port=C wr addr=010 wdata=BEEF ack cycle=2", $time);
        tick();

        xfer(0, 1, 0, 12'h010, 16'h0000, 2 + RL, 16'hBEEF, "rd_c");
        xfer(1, 0, 1, 12'h020, 16'h5A5A, 2, 16'h0000, "wr_h");

        // First tie after reset.
        reset_pulse();
`ifdef MU0_ARB_HOST_PRIORITY_EN
        tie(2 * (2 + RL), 2 + RL, "tie1");
`else
        tie(2 + RL, 2 * (2 + RL), "tie1");
`endif
        // CPU-only access makes C the last grant; next tie goes to the host.
        xfer(0, 1, 0, 12'h020, 16'h0000, 2 + RL, 16'h5A5A, "rd_c2");
        tie(2 * (2 + RL), 2 + RL, "tie2");

        // Continuous write traffic from both ports, 8 transactions.
        reset_pulse();
        n = 0; c_n = 0; h_n = 0; cyc = 0;
        bus.c_address = 12'h100; bus.c_writedata = 16'hC000; bus.c_write = 1'b1;
        bus.h_address = 12'h200; bus.h_writedata = 16'hD000; bus.h_write = 1'b1;
        while (n < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            c_ack = bus.c_write && !bus.c_waitrequest;
            h_ack = bus.h_write && !bus.h_waitrequest;
            if (c_ack) begin order[n] = 0; n++; c_n++; end
            if (h_ack) begin order[n] = 1; n++; h_n++; end
            if (c_ack || h_ack)
                $display("[%0t] rr ack #%0d port=%s cycle=%0d", $time, n, c_ack ? "C" : "H", cyc);
            tick();
            if (c_ack) begin
                if (c_n == 4) bus.c_write = 1'b0;
                else begin
                    c_next_addr = bus.c_address + 12'd1;
                    bus.c_address = c_next_addr; bus.c_writedata = 16'hC000 | 16'(c_n);
                end
            end
            if (h_ack) begin
                if (h_n == 4) bus.h_write = 1'b0;
                else begin
                    bus.h_address = bus.h_address + 12'd1; bus.h_writedata = 16'hD000 | 16'(h_n);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
`ifdef MU0_ARB_HOST_PRIORITY_EN
            exp_port = (i < 4) ? 1 : 0;
`else
            exp_port = i % 2;
`endif
            check_eq($sformatf("rr_order%0d", i), order[i], exp_port);
        end
        check_eq("rr_c_count", c_n, 4);
        check_eq("rr_h_count", h_n, 4);
        check_eq("rr_cycles", cyc, 16);
        check_eq("rr_memval_c", tb_mem[12'h103], 16'hC003);
        check_eq("rr_memval_h", tb_mem[12'h203], 16'hD003);

        // Reset during WAIT of a host read, then re-arbitration.
        bus.h_address = 12'h020; bus.h_read = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        @(negedge clk);
        check_eq("arst_h_wait", bus.h_waitrequest, 1);
        check_eq("arst_h_rdata", bus.h_readdata, 0);
        check_eq("arst_mem_read", bus.mem_read, 0);
        check_eq("arst_mem_addr", bus.mem_address, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            check_eq($sformatf("arst_hold%0d_strobe", i), bus.mem_read | bus.mem_write, 0);
            check_eq($sformatf("arst_hold%0d_wait", i), bus.h_waitrequest, 1);
        end
        tick();
        rst = 1'b0;
        $display("[%0t] arst host read aborted by reset", $time);
        xfer(1, 1, 0, 12'h020, 16'h0000, 2 + RL, 16'h5A5A, "rearb_h");

        // Read and write together: performed as a write, err becomes sticky.
        check_eq("err_before", err, 0);
        xfer(1, 1, 1, 12'h0FF, 16'h1234, 2, 16'h0000, "rw_h");
        @(negedge clk);
        check_eq("err_set", err, 1);
        tick();
        tick();
        xfer(0, 1, 0, 12'h0FF, 16'h0000, 2 + RL, 16'h1234, "rd_c3");
        @(negedge clk);
        check_eq("err_sticky", err, 1);
        tick();
        reset_pulse();
        @(negedge clk);
        check_eq("err_cleared", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
